uart_tx_fifo: RTL and testbench

Buffered RS232 transmitter producing 8N1 frames at 115200 or 230400 bps from the 25 MHz system clock. The baud timing matches the existing receiver: bit period is limit+1 clocks, where limit is 217 or 109 and is selected by fsel. A small FIFO decouples the CPU's I/O write strobe from line timing. Frames go out back-to-back while the FIFO holds data. Sits in the SoC I/O block beside uart_rx on the same serial port.

---
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 93 +++++++++
 tb/tb_uart_tx_fifo.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU write port and serial line of the buffered UART transmitter.
interface uart_tx_fifo_if #(parameter int DEPTH_LOG2 = 3);
  logic                fsel;
  logic                wr;
  logic [7:0]          data;
  logic                rdy;
  logic                busy;
  logic [DEPTH_LOG2:0] level;
  logic                TxD;
  modport master (output fsel, wr, data, input rdy, busy, level, TxD);
  modport slave  (input fsel, wr, data, output rdy, busy, level, TxD);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 transmitter, back-to-back frames, bit period limit+1 clocks.
module uart_tx_fifo #(
  parameter int LIMIT_SLOW = 217,
  parameter int LIMIT_FAST = 109,
  parameter int DEPTH_LOG2 = 3
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [DEPTH_LOG2:0] ONE = 1;
  state_t              state_q, state_d;
  logic [7:0]          mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wp_q, rp_q, level;
  logic [11:0]         tick_q, tick_d, limit;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                fsel_q, fsel_d, txd_q, txd_d;
  logic                full, empty, push, pop, bit_end;
  assign level    = wp_q - rp_q;
  assign full     = level == {1'b1, {DEPTH_LOG2{1'b0}}};
  assign empty    = level == '0;
  assign push     = bus.wr & ~full;
  assign limit    = fsel_q ? 12'(LIMIT_FAST) : 12'(LIMIT_SLOW);
  assign bit_end  = tick_q == limit;
  assign bus.rdy   = ~full;
  assign bus.busy  = (state_q != IDLE) | ~empty;
  assign bus.level = level;
  assign bus.TxD   = txd_q;
  always_ff @(posedge clk)
    if (push) mem[wp_q[DEPTH_LOG2-1:0]] <= bus.data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      tick_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      fsel_q   <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wp_q     <= push ? wp_q + ONE : wp_q;
      rp_q     <= pop ? rp_q + ONE : rp_q;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      fsel_q   <= fsel_d;
      txd_q    <= txd_d;
    end
  // Popping from STOP straight into START keeps frames contiguous.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q + 12'd1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    fsel_d   = fsel_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        tick_d   = '0;
        bitcnt_d = '0;
        state_d  = DATA;
      end
      DATA: if (bit_end) begin
        tick_d   = '0;
        shreg_d  = {1'b0, shreg_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) state_d = STOP;
      end
      default: if (bit_end) begin
        tick_d  = '0;
        pop     = ~empty;
        state_d = empty ? IDLE : START;
      end
    endcase
    if (pop) begin
      shreg_d = mem[rp_q[DEPTH_LOG2-1:0]];
      fsel_d  = bus.fsel;
    end
  end
  // The line level is computed from the next state so TxD stays a clean flop output.
  always_comb txd_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : 1'b1;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus checked every cycle against a frame-level model.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  uart_tx_fifo_if bus ();
  uart_tx_fifo dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] q[$];
  bit         act;
  int         fs, fp, n;
  logic [7:0] fb;
  logic       fcur;
  int         n_pass, n_total;
  function automatic logic exp_txd();
    int k;
    if (!act) return 1'b1;
    k = (n - fs) / fp;
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : fb[k-1];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic model_edge(input logic w, input logic [7:0] d, input logic f);
    int sz;
    n++;
    sz = q.size();
    if (act && n == fs + 10 * fp) act = 0;
    if (!act && q.size() > 0) begin
      fb  = q.pop_front();
      fp  = f ? 110 : 218;
      fs  = n;
      act = 1;
    end
    if (w && sz < 8) q.push_back(d);
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic f);
    logic [6:0] e;
    bus.wr = w;
    bus.data = d;
    bus.fsel = f;
    fcur = f;
    @(posedge clk);
    model_edge(w, d, f);
    #1;
    e = {exp_txd(), q.size() < 8 ? 1'b1 : 1'b0, (act || q.size() > 0) ? 1'b1 : 1'b0, 4'(q.size())};
    chk("outs{txd,rdy,busy,level}", {25'd0, bus.TxD, bus.rdy, bus.busy, bus.level}, {25'd0, e});
  endtask
  task automatic drain();
    int i = 0;
    while (bus.busy && i < 30000) begin
      step(1'b0, 8'h00, fcur);
      i++;
    end
    chk("drain_busy", {31'd0, bus.busy}, 32'd0);
  endtask
  task automatic do_reset();
    bus.wr = 1'b0;
    rst = 1'b1;
    #3;
    q.delete();
    act = 0;
    chk("rst_outs", {25'd0, bus.TxD, bus.rdy, bus.busy, bus.level}, {25'd0, 7'b1100000});
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask
  initial begin
    int i;
    logic w;
    n_pass = 0;
    n_total = 0;
    n = 0;
    act = 0;
    fcur = 1'b0;
    bus.wr = 1'b0;
    bus.data = 8'h00;
    bus.fsel = 1'b0;
    rst = 1'b1;
    #1;
    do_reset();
    // single slow byte: latency, bit pattern and busy duration
    step(1'b1, 8'h55, 1'b0);
    chk("t1_txd_edge1", {31'd0, bus.TxD}, 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_txd_edge2", {31'd0, bus.TxD}, 32'd0);
    i = 0;
    while (bus.busy && i < 5000) begin
      step(1'b0, 8'h00, 1'b0);
      i++;
    end
    chk("t1_busy_len", i, 2180);
    // fast burst until the FIFO refuses a write; frames must run back-to-back
    for (int k = 0; k < 10; k++) step(1'b1, k < 8 ? 8'(k) : (k == 8 ? 8'hAA : 8'hBB), 1'b1);
    chk("t2_level_full", {28'd0, bus.level}, 32'd8);
    chk("t2_rdy_full", {31'd0, bus.rdy}, 32'd0);
    drain();
    // fsel change mid-frame only affects the following frame
    step(1'b1, 8'hA3, 1'b0);
    for (int k = 0; k < 500; k++) step(1'b0, 8'h00, 1'b0);
    drain_fast_switch: begin
      step(1'b0, 8'h00, 1'b1);
      drain();
    end
    step(1'b1, 8'h3C, 1'b1);
    drain();
    // full FIFO: write on the pop edge is refused, the next one is taken
    i = 0;
    while (bus.level != 4'd8 && i < 20) begin
      step(1'b1, 8'($urandom), 1'b1);
      i++;
    end
    chk("t4_filled", {28'd0, bus.level}, 32'd8);
    i = 0;
    while (bus.level == 4'd8 && i < 2000) begin
      step(1'b1, 8'($urandom), 1'b1);
      i++;
    end
    chk("t4_pop_edge_level", {28'd0, bus.level}, 32'd7);
    step(1'b1, 8'($urandom), 1'b1);
    chk("t4_next_write_level", {28'd0, bus.level}, 32'd8);
    drain();
    // reset during data bit 4 with three bytes queued
    for (int k = 0; k < 4; k++) step(1'b1, 8'($urandom), 1'b0);
    chk("t5_queued", {28'd0, bus.level}, 32'd3);
    i = 0;
    while (!(act && (n - fs) / fp == 5) && i < 3000) begin
      step(1'b0, 8'h00, 1'b0);
      i++;
    end
    for (int k = 0; k < 50; k++) step(1'b0, 8'h00, 1'b0);
    do_reset();
    for (int k = 0; k < 3000; k++) step(1'b0, 8'h00, 1'b0);
    chk("t5_quiet_txd", {31'd0, bus.TxD}, 32'd1);
    // random traffic with occasional rate changes
    w = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(0, 999) == 0) fcur = ~fcur;
      w = $urandom_range(0, 599) < 3;
      step(w, 8'($urandom), fcur);
    end
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
